seq_div_scheduler: RTL

SEQ_DIV_SCHEDULER -- requirements
Module: seq_div_scheduler

---
 rtl/seq_div_scheduler.sv | 131 +++++++++++++
 1 files changed

// File: rtl/seq_div_scheduler.sv
// rtl/seq_div_scheduler.sv - round-robin scheduler sharing one sequential divider among four requesters
module seq_div_scheduler #(
  parameter int LATENCY = 268,
  parameter int NREQ    = 4
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   req_count,
  input  logic [16*NREQ-1:0]   req_divider,
  output logic [NREQ-1:0]      grant,
  output logic [8*NREQ-1:0]    result,
  output logic [NREQ-1:0]      result_valid,
  output logic                 busy,
  output logic                 div_flag,
  output logic [15:0]          div_count,
  output logic [15:0]          div_divider,
  input  logic [7:0]           div_q
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPTURE, GAP} state_t;

  localparam logic [9:0] RUN_LAST = 10'(LATENCY - 1);

  state_t      state;
  state_t      next_state;
  logic [1:0]  rr_ptr;
  logic [1:0]  win_idx;
  logic [1:0]  cand;
  logic        win_found;
  logic [1:0]  op_idx;
  logic [15:0] op_count;
  logic [15:0] op_divider;
  logic [9:0]  run_cnt;
  logic        bypass;
  logic        load_bypass;

  // A job the divider cannot produce an 8-bit fraction for skips the divider entirely.
  assign load_bypass = (op_divider == 16'd0) || (op_count >= op_divider);

  assign busy     = (state != IDLE);
  assign div_flag = (state == RUN);

  // Round-robin search: first active requester at or after rr_ptr, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr;
    cand      = rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      cand = rr_ptr + 2'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // State register; reset kills any job in flight and drops div_flag at once.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and the grant pulse; grant is masked while reset is held.
  always_comb begin
    next_state = state;
    grant      = '0;
    case (state)
      IDLE: begin
        if (win_found) begin
          next_state     = LOAD;
          grant[win_idx] = nrst;
        end
      end
      LOAD:    next_state = load_bypass ? CAPTURE : RUN;
      RUN:     if (run_cnt == RUN_LAST) next_state = CAPTURE;
      CAPTURE: next_state = GAP;
      GAP:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: operand latch at grant, divider drive, run counter and result write-back.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rr_ptr       <= '0;
      op_idx       <= '0;
      op_count     <= '0;
      op_divider   <= '0;
      run_cnt      <= '0;
      bypass       <= 1'b0;
      div_count    <= '0;
      div_divider  <= '0;
      result       <= '0;
      result_valid <= '0;
    end else begin
      result_valid <= '0;
      case (state)
        IDLE: begin
          if (win_found) begin
            op_idx     <= win_idx;
            op_count   <= req_count[{win_idx, 4'b0000} +: 16];
            op_divider <= req_divider[{win_idx, 4'b0000} +: 16];
            rr_ptr     <= win_idx + 2'd1;
          end
        end
        LOAD: begin
          run_cnt <= '0;
          bypass  <= load_bypass;
          if (!load_bypass) begin
            div_count   <= op_count;
            div_divider <= op_divider;
          end
        end
        RUN: begin
          run_cnt <= run_cnt + 10'd1;
        end
        CAPTURE: begin
          result[{op_idx, 3'b000} +: 8] <= bypass ? 8'hFF : div_q;
          result_valid[op_idx]          <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
